// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmit-frame interface
//
// Purpose: NREQ requesters each offer one FW-bit frame via valid/ready. The
// arbiter grants round-robin, latches the winning frame onto tx_in, pulses
// tx_trigger for one cycle and then holds off for GAP_CYCLES cycles.
//
// Ports:
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   req_valid    per-requester frame-available flags
//   req_frame    requester i frame at bits [i*FW +: FW]
//   req_ready    one-hot accept strobe (combinational, IDLE and not tx_full only)
//   tx_full      UART core TX FIFO full
//   tx_in        frame presented to the UART core
//   tx_trigger   one-cycle write strobe to the UART core
//   grant_id     index of the last accepted requester
//   busy         high whenever the arbiter is not idle
//   frames_sent  number of triggers issued, wrapping

module uart_tx_arbiter #(
    parameter  int NREQ            = 4,
    parameter  int DBITS           = 8,
    parameter  int UART_FRAME_SIZE = 4,
    parameter  int GAP_CYCLES      = 0,
    parameter  int CNT_W           = 16,
    localparam int FW              = UART_FRAME_SIZE * DBITS,
    localparam int IW              = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*FW-1:0]   req_frame,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 tx_full,
    output logic [FW-1:0]        tx_in,
    output logic                 tx_trigger,
    output logic [IW-1:0]        grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     frames_sent
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // Loaded on GAP entry so that exactly GAP_CYCLES cycles are spent in GAP.
    localparam logic [15:0] GAP_LOAD = (GAP_CYCLES > 0) ? 16'(GAP_CYCLES - 1) : 16'd0;

    state_t           state_q, state_d;
    logic [FW-1:0]    tx_in_q, tx_in_d;
    logic [IW-1:0]    last_q, last_d;
    logic [CNT_W-1:0] frames_q, frames_d;
    logic [15:0]      gap_q, gap_d;

    logic             sel_found;
    logic [IW-1:0]    sel_idx;
    logic [IW:0]      cand;

    // Round-robin search starting just after the last grant. The extra bit in
    // cand holds last+k (at most 2*NREQ-1) before folding back into range.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NREQ)) begin
                cand = cand - (IW+1)'(NREQ);
            end
            if (!sel_found && req_valid[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_in_d    = tx_in_q;
        last_d     = last_q;
        frames_d   = frames_q;
        gap_d      = gap_q;
        req_ready  = '0;
        tx_trigger = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!tx_full && sel_found) begin
                    req_ready[sel_idx] = 1'b1;
                    tx_in_d            = req_frame[int'(sel_idx)*FW +: FW];
                    last_d             = sel_idx;
                    state_d            = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // No tx_full check here: FIFO room was confirmed at accept and
                // nothing else writes the FIFO.
                tx_trigger = 1'b1;
                frames_d   = frames_q + CNT_W'(1);
                if (GAP_CYCLES > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = S_GAP;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_q == 16'd0) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q - 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            tx_in_q  <= '0;
            last_q   <= IW'(NREQ - 1);
            frames_q <= '0;
            gap_q    <= '0;
        end else begin
            state_q  <= state_d;
            tx_in_q  <= tx_in_d;
            last_q   <= last_d;
            frames_q <= frames_d;
            gap_q    <= gap_d;
        end
    end

    assign tx_in       = tx_in_q;
    assign grant_id    = last_q;
    assign busy        = (state_q != S_IDLE);
    assign frames_sent = frames_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed self-checking bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A: GAP_CYCLES=0, CNT_W=4 (wrap test)
    logic [3:0]   a_valid;
    logic [127:0] a_frame;
    logic [3:0]   a_ready;
    logic         a_full;
    logic [31:0]  a_tx_in;
    logic         a_trig;
    logic [1:0]   a_gid;
    logic         a_busy;
    logic [3:0]   a_cnt;

    // Instance B: GAP_CYCLES=3, CNT_W=16
    logic [3:0]   b_valid;
    logic [127:0] b_frame;
    logic [3:0]   b_ready;
    logic         b_full;
    logic [31:0]  b_tx_in;
    logic         b_trig;
    logic [1:0]   b_gid;
    logic         b_busy;
    logic [15:0]  b_cnt;

    uart_tx_arbiter #(.NREQ(4), .DBITS(8), .UART_FRAME_SIZE(4), .GAP_CYCLES(0), .CNT_W(4)) dut_a (
        .clk(clk), .reset_n(reset_n), .req_valid(a_valid), .req_frame(a_frame),
        .req_ready(a_ready), .tx_full(a_full), .tx_in(a_tx_in), .tx_trigger(a_trig),
        .grant_id(a_gid), .busy(a_busy), .frames_sent(a_cnt)
    );

    uart_tx_arbiter #(.NREQ(4), .DBITS(8), .UART_FRAME_SIZE(4), .GAP_CYCLES(3), .CNT_W(16)) dut_b (
        .clk(clk), .reset_n(reset_n), .req_valid(b_valid), .req_frame(b_frame),
        .req_ready(b_ready), .tx_full(b_full), .tx_in(b_tx_in), .tx_trigger(b_trig),
        .grant_id(b_gid), .busy(b_busy), .frames_sent(b_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        a_valid = '0; a_full = 1'b0; a_frame = '0;
        b_valid = '0; b_full = 1'b0; b_frame = '0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    logic [31:0] exp_f [4];
    int n_trig;
    int t_idx;

    initial begin
        exp_f[0] = 32'h11111111;
        exp_f[1] = 32'h22222222;
        exp_f[2] = 32'h33333333;
        exp_f[3] = 32'h44444444;

        // Reset state
        reset_n = 1'b0;
        a_valid = '0; a_full = 1'b0; a_frame = '0;
        b_valid = '0; b_full = 1'b0; b_frame = '0;
        tick();
        check("rst_trig", a_trig, 0);
        check("rst_tx_in", a_tx_in, 0);
        check("rst_gid", a_gid, 3);
        check("rst_busy", a_busy, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_ready", a_ready, 0);
        check("rst_b_gid", b_gid, 3);
        tick();
        reset_n = 1'b1;

        // Single frame from requester 0
        a_valid = 4'b0001;
        a_frame = {96'h0, 32'h41414141};
        #1;
        check("t1_ready", a_ready, 4'b0001);
        tick();
        a_valid = '0;
        check("t1_trig", a_trig, 1);
        check("t1_tx_in", a_tx_in, 32'h41414141);
        check("t1_gid", a_gid, 0);
        check("t1_busy", a_busy, 1);
        tick();
        check("t1_trig_off", a_trig, 0);
        check("t1_cnt", a_cnt, 1);
        check("t1_tx_hold", a_tx_in, 32'h41414141);

        // All four valid, GAP=0: triggers every 2 cycles, grants 0,1,2,3,0
        do_reset();
        a_valid = 4'hF;
        a_frame = {exp_f[3], exp_f[2], exp_f[1], exp_f[0]};
        #1;
        check("t2_ready0", a_ready, 4'b0001);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check("t2_trig", a_trig, (k % 2 == 1) ? 1 : 0);
            if (k % 2 == 1) begin
                check("t2_tx_in", a_tx_in, exp_f[((k - 1) / 2) % 4]);
                check("t2_gid", a_gid, ((k - 1) / 2) % 4);
            end else begin
                check("t2_ready", a_ready, 4'b0001 << ((k / 2) % 4));
            end
        end
        a_valid = '0;
        tick();
        check("t2_cnt", a_cnt, 5);

        // tx_full blocks accept for 10 cycles, release accepts same cycle
        a_full = 1'b1;
        a_valid = 4'b0010;
        a_frame = {32'h0, 32'h0, 32'hA5A5A5A5, 32'h0};
        for (int k = 0; k < 10; k++) begin
            tick();
            check("t3_ready_blk", a_ready, 0);
            check("t3_trig_blk", a_trig, 0);
        end
        a_full = 1'b0;
        #1;
        check("t3_ready_rel", a_ready, 4'b0010);
        tick();
        a_valid = '0;
        check("t3_trig", a_trig, 1);
        check("t3_tx_in", a_tx_in, 32'hA5A5A5A5);
        check("t3_gid", a_gid, 1);
        tick();
        check("t3_cnt", a_cnt, 6);

        // Reset asserted during ISSUE
        a_valid = 4'b0100;
        a_frame = {32'h0, 32'h5A5A5A5A, 32'h0, 32'h0};
        tick();
        a_valid = '0;
        check("t5_trig_pre", a_trig, 1);
        check("t5_gid_pre", a_gid, 2);
        reset_n = 1'b0;
        #1;
        check("t5_trig_rst", a_trig, 0);
        check("t5_cnt_rst", a_cnt, 0);
        check("t5_tx_in_rst", a_tx_in, 0);
        check("t5_busy_rst", a_busy, 0);
        tick();
        reset_n = 1'b1;
        a_valid = 4'hF;
        a_frame = {exp_f[3], exp_f[2], exp_f[1], exp_f[0]};
        #1;
        check("t5_ready_post", a_ready, 4'b0001);

        // Counter wrap at CNT_W=4: 17 frames -> frames_sent reads 1
        n_trig = 0;
        for (int c = 0; c < 100; c++) begin
            tick();
            if (a_trig) begin
                n_trig++;
                if (n_trig == 1) check("t5_first_gid", a_gid, 0);
                if (n_trig == 17) begin
                    a_valid = '0;
                    break;
                end
            end
        end
        check("t6_ntrig", n_trig, 17);
        tick();
        check("t6_cnt_wrap", a_cnt, 1);

        // GAP_CYCLES=3, requesters 0 and 2: spacing 5, grants 0,2,0,2
        do_reset();
        b_valid = 4'b0101;
        b_frame = {32'h0, 32'hCCCC0002, 32'h0, 32'hCCCC0000};
        t_idx = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            check("t4_trig", b_trig, (k % 5 == 1) ? 1 : 0);
            if (k % 5 == 1) begin
                check("t4_gid", b_gid, (t_idx % 2 == 1) ? 2 : 0);
                check("t4_tx_in", b_tx_in, (t_idx % 2 == 1) ? 32'hCCCC0002 : 32'hCCCC0000);
                t_idx++;
            end
            if (k % 5 == 2 || k % 5 == 3 || k % 5 == 4) begin
                check("t4_ready_gap", b_ready, 0);
                check("t4_busy_gap", b_busy, 1);
            end
        end
        check("t4_ready_idle", b_ready, 4'b0001);
        b_valid = '0;
        tick();
        check("t4_cnt", b_cnt, 4);
        check("t4_trig_end", b_trig, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single transmit-frame interface of uart_top (tx_in / tx_trigger) between NREQ independent requesters, e.g. button handler, flag responder and debug dumper.
- Each requester offers one UART_FRAME_SIZE-byte frame through a valid/ready handshake.
- The arbiter picks requesters round-robin and latches the winner's frame.
- It drives a one-cycle tx_trigger into the UART core, then enforces an inter-frame gap.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DBITS, 8, bits per UART character.
- UART_FRAME_SIZE, 4, characters per frame; frame width FW = UART_FRAME_SIZE*DBITS.
- GAP_CYCLES, 0, idle cycles forced after each trigger (0..65535).
- CNT_W, 16, width of frames_sent counter.

Ports:
- clk  in  1  system clock (100 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-requester frame-available flag.
- req_frame  in  NREQ*FW  requester i frame at bits [i*FW +: FW].
- req_ready  out  NREQ  one-hot accept strobe; transfer occurs when req_valid[i] & req_ready[i].
- tx_full  in  1  UART core TX FIFO full.
- tx_in  out  FW  frame presented to uart_top.tx_in.
- tx_trigger  out  1  one-cycle write strobe to uart_top.tx_trigger.
- grant_id  out  $clog2(NREQ)  index of the last accepted requester.
- busy  out  1  high in any state other than IDLE.
- frames_sent  out  CNT_W  count of issued triggers, wraps modulo 2^CNT_W.

Behaviour:
- Reset values (async assert, sync release):
  - state=IDLE, tx_in=0, tx_trigger=0, grant_id=NREQ-1, busy=0, frames_sent=0, gap counter=0.
  - Internal last-grant pointer = NREQ-1, so requester 0 has first priority.
- IDLE:
  - If tx_full=0 and any req_valid is high, select the first valid index searching (last+1) mod NREQ upward with wrap.
  - req_ready is combinational, one-hot at the selected index, and only in IDLE with tx_full=0; otherwise all zero.
  - On transfer: latch the selected frame into tx_in, set grant_id and the last-grant pointer to that index, and go to ISSUE.
  - If tx_full=1, or no request is valid, stay in IDLE with req_ready=0.
- ISSUE (exactly 1 cycle):
  - tx_trigger=1, tx_in stable, frames_sent increments on the following edge.
  - Next state is GAP if GAP_CYCLES>0, otherwise IDLE.
  - tx_full is not sampled in ISSUE; the trigger is always issued. The arbiter is the sole writer of the TX FIFO, and room was checked at accept.
- GAP:
  - Counter loads GAP_CYCLES-1 on entry and decrements each cycle.
  - Go to IDLE when the counter reaches 0 (exactly GAP_CYCLES cycles in GAP).
  - req_ready=0 throughout.
- tx_in holds the last issued frame until the next accept; it is never cleared except by reset.
- Latency and throughput:
  - Accept at edge N, tx_trigger high during cycle N+1.
  - Earliest next accept is cycle N+2+GAP_CYCLES.
  - Peak rate is one frame per (2+GAP_CYCLES) cycles.
- Fairness: with all requesters continuously valid, grants cycle 0,1,2,...,NREQ-1,0,... and no requester waits more than NREQ grants.
- A requester may drop req_valid before being accepted; no frame is taken. Frame data needs to be stable only in the accept cycle.
- Simultaneous events:
  - tx_full rising in the same cycle as a would-be accept blocks the accept.
  - A newly valid requester during ISSUE or GAP is considered at the next IDLE.
- Reset mid-operation:
  - An in-flight ISSUE is aborted and tx_trigger drops immediately.
  - The latched frame is discarded and frames_sent clears.
  - Requester state is the requesters' responsibility.
- frames_sent wraps 2^CNT_W-1 -> 0 with no flag.

Test Plan:
- Reset, then req_valid=0001 with frame 0x41414141 and tx_full=0:
  - req_ready=0001 in that cycle.
  - Next cycle tx_trigger=1 and tx_in=0x41414141.
  - frames_sent=1 and grant_id=0.
- All four valid with distinct frames 0x11111111..0x44444444, GAP_CYCLES=0:
  - Triggers every 2 cycles in grant order 0,1,2,3,0.
  - tx_in matches each granted frame.
- tx_full=1 with req_valid=0010 for 10 cycles:
  - req_ready=0 and no trigger throughout.
  - Release tx_full: accept occurs in that same cycle, trigger on the next.
- GAP_CYCLES=3 with requesters 0 and 2 continuously valid:
  - Trigger spacing is exactly 5 cycles.
  - Grants alternate 0,2,0,2.
- Assert reset_n=0 during ISSUE:
  - tx_trigger=0 and frames_sent=0 asynchronously.
  - After release, requester 0 wins the first grant.
- CNT_W=4, 17 frames issued: frames_sent reads 1 after wrap.
